// File: rtl/apb_master.sv
// APB master bridging a one-cycle CPU request strobe onto four APB slaves
// (RAM, GPIO, UART, TIMER) with wait-state timeout and error reporting.
module apb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transfer,
    input  logic        busWe,
    input  logic [31:0] busAddr,
    input  logic [31:0] busWData,
    output logic [31:0] busRData,
    output logic        ready,
    output logic        slvErr,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int          CW          = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
    localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   paddr_q;
    logic [31:0]   pwdata_q;
    logic          pwrite_q;
    logic [3:0]    sel_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q;
    logic          ready_q;
    logic          err_q;

    logic [3:0]    dec_sel;
    logic [3:0]    pready_vec;
    logic [31:0]   prdata_arr [4];
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          take;
    logic          access_done;
    logic          timeout_hit;

    assign prdata_arr[0] = PRDATA0;
    assign prdata_arr[1] = PRDATA1;
    assign prdata_arr[2] = PRDATA2;
    assign prdata_arr[3] = PRDATA3;
    assign pready_vec    = {PREADY3, PREADY2, PREADY1, PREADY0};

    // One 4 KiB window per slave inside the 0x1000_xxxx page.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign dec_sel[gi] = (busAddr[31:16] == 16'h1000) &&
                                 (busAddr[15:12] == 4'(gi));
        end
    endgenerate

    // Unmapped accesses (no select) complete immediately with zero data.
    always_comb begin
        sel_ready = (sel_q == 4'b0000);
        sel_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) begin
                sel_ready = sel_ready | pready_vec[i];
                sel_rdata = sel_rdata | prdata_arr[i];
            end
        end
    end

    assign take        = (state_q == IDLE) && transfer;
    assign access_done = (state_q == ACCESS) && sel_ready;
    assign timeout_hit = (state_q == ACCESS) && !sel_ready && (cnt_q == TIMEOUT_C);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (access_done || timeout_hit) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request capture and completion reporting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q  <= 32'h0;
            pwdata_q <= 32'h0;
            pwrite_q <= 1'b0;
            sel_q    <= 4'b0000;
            rdata_q  <= 32'h0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (take) begin
                paddr_q  <= busAddr;
                pwdata_q <= busWData;
                pwrite_q <= busWe;
                sel_q    <= dec_sel;
            end
            ready_q <= access_done || timeout_hit;
            err_q   <= timeout_hit;
            if (timeout_hit) begin
                rdata_q <= ERR_DATA;
            end else if (access_done && !pwrite_q) begin
                rdata_q <= sel_rdata;
            end
        end
    end

    // Output logic: selects and enable follow the phase directly.
    always_comb begin
        PSEL0   = 1'b0;
        PSEL1   = 1'b0;
        PSEL2   = 1'b0;
        PSEL3   = 1'b0;
        PENABLE = 1'b0;
        if (state_q != IDLE) begin
            PSEL0 = sel_q[0];
            PSEL1 = sel_q[1];
            PSEL2 = sel_q[2];
            PSEL3 = sel_q[3];
        end
        if (state_q == ACCESS) begin
            PENABLE = 1'b1;
        end
    end

    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;
    assign busRData = rdata_q;
    assign ready    = ready_q;
    assign slvErr   = err_q;

endmodule
